// File: rtl/system_pio_pkg.sv
// Shared constants for the input PIO: register word addresses, edge modes, bus width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package system_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum int {
    EDGE_RISING  = 0,
    EDGE_FALLING = 1,
    EDGE_ANY     = 2
  } edge_type_e;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronizes an asynchronous input bus and flags per-bit edges against the previous sample.
// Latency: data_in lags in_port by SYNC_STAGES clocks; edge_pulse is combinational from data_in/prev.
// Backpressure: none; samples every cycle.
// Ports: clk, reset_n (async, active-low), in_port (async inputs),
//        data_in (synchronized bus), edge_pulse (one-cycle edge flags, mode set by EDGE_TYPE).
module pio_sync_edge
  import system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev <= data_in;
    end
  end

  assign data_in = sync_q[SYNC_STAGES-1];

  // prev and data_in both reset to 0, so no edge fires on the first cycle after reset.
  generate
    if (EDGE_TYPE == int'(EDGE_RISING)) begin : g_rise
      assign edge_pulse = data_in & ~prev;
    end else if (EDGE_TYPE == int'(EDGE_FALLING)) begin : g_fall
      assign edge_pulse = ~data_in & prev;
    end else begin : g_any
      assign edge_pulse = data_in ^ prev;
    end
  endgenerate

endmodule

// File: rtl/system_pio_in.sv
// Avalon-MM input PIO: synchronized input data, sticky edge capture with W1C, maskable level irq.
// Latency: readdata 1 cycle after address; irq 1 cycle after edge_capture/mask change.
// Backpressure: none; no waitrequest, writes always accepted.
// Ports: clk, reset_n (async, active-low), address/chipselect/write_n/writedata (slave write side),
//        in_port (async inputs), readdata (registered), irq (level, active-high).
// Build option: define PIO_IN_IRQ_EN to build the IRQMASK register and irq; otherwise irq is 0.
module system_pio_in
  import system_pio_pkg::*;
#(
  parameter int                WIDTH       = 8,
  parameter int                EDGE_TYPE   = 0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_MASK  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] mask_rd;
  logic [DATA_W-1:0] rd_next;
  logic              wr_en;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .data_in   (data_in),
    .edge_pulse(edge_pulse)
  );

  assign wr_en    = chipselect && !write_n;
  assign edge_clr = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // Set is OR'd in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~edge_clr) | edge_pulse;
  end

`ifdef PIO_IN_IRQ_EN
  logic [WIDTH-1:0] irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= RESET_MASK[WIDTH-1:0];
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
      irq <= |(edge_capture & irq_mask);
    end
  end

  assign mask_rd = irq_mask;
`else
  logic [DATA_W-1:0] unused_reset_mask;

  assign unused_reset_mask = RESET_MASK;
  assign mask_rd           = '0;
  assign irq               = 1'b0;
`endif

  // Read path ignores chipselect: the fabric only samples readdata on its own reads.
  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = data_in;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = mask_rd;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edge_capture;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  generate
    if (WIDTH < DATA_W) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = |writedata[DATA_W-1:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_system_pio_in.sv
// Directed self-checking bench for system_pio_in with default parameters (WIDTH=8, rising, 2 stages).
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_system_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  system_pio_in dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'hA5;
    tick(2);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    // 1: DATA reflects stable inputs after the synchronizer fills
    reset_n = 1'b1;
    tick(4);
    bus_read(2'd0, rd);
    check("data_a5", rd, 32'h0000_00A5);
    check("irq_idle", {31'h0, irq}, 32'h0);

    // Release from reset with 0xA5 applied looks like rising edges on those bits
    bus_read(2'd3, rd);
    check("edgecap_after_reset", rd, 32'h0000_00A5);

    // 2: rising capture, stickiness, W1C
    in_port = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFF);
    bus_read(2'd3, rd);
    check("edgecap_cleared", rd, 32'h0);
    in_port = 8'h01;
    tick(4);
    bus_read(2'd3, rd);
    check("edgecap_rise_b0", rd, 32'h01);
    in_port = 8'h00;
    tick(4);
    bus_read(2'd3, rd);
    check("edgecap_sticky", rd, 32'h01);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3, rd);
    check("edgecap_w1c", rd, 32'h0);

    // 3: irq generation and masking
`ifdef PIO_IN_IRQ_EN
    bus_write(2'd2, 32'h01);
    bus_read(2'd2, rd);
    check("mask_rd", rd, 32'h01);
    in_port = 8'h01;
    tick(3);
    check("irq_before", {31'h0, irq}, 32'h0);
    tick(1);
    check("irq_set", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h00);
    check("irq_mask_lag", {31'h0, irq}, 32'h1);
    tick(1);
    check("irq_masked", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'h01);
    bus_write(2'd2, 32'h01);
    tick(2);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    in_port = 8'h00;
    tick(4);
    bus_write(2'd2, 32'h00);
`else
    bus_write(2'd2, 32'hFF);
    bus_read(2'd2, rd);
    check("mask_absent_rd", rd, 32'h0);
    in_port = 8'h01;
    tick(4);
    check("irq_tied", {31'h0, irq}, 32'h0);
    bus_write(2'd3, 32'h01);
    in_port = 8'h00;
    tick(4);
`endif

    // 4: edge on bit3 lands on the same edge as a W1C of bit3 -> set wins
    bus_read(2'd3, rd);
    check("edgecap_pre_race", rd, 32'h0);
    in_port = 8'h08;
    tick(2);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3, rd);
    check("edgecap_set_wins", rd, 32'h08);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3, rd);
    check("edgecap_race_clr", rd, 32'h0);

    // 5: writes to read-only/reserved addresses are ignored
    in_port = 8'h3C;
    tick(4);
    bus_write(2'd0, 32'hFF);
    bus_write(2'd1, 32'hFF);
    bus_read(2'd0, rd);
    check("data_ro", rd, 32'h3C);
    bus_read(2'd1, rd);
    check("rsvd_zero", rd, 32'h0);

    // 6: asynchronous reset mid-operation
    in_port = 8'h00;
    tick(4);
    bus_write(2'd3, 32'hFF);
    in_port = 8'h0F;
    tick(4);
    bus_read(2'd3, rd);
    check("edgecap_0f", rd, 32'h0F);
`ifdef PIO_IN_IRQ_EN
    bus_write(2'd2, 32'hFF);
    tick(2);
    check("irq_pre_reset", {31'h0, irq}, 32'h1);
`else
    bus_write(2'd2, 32'hFF);
    tick(2);
    check("irq_pre_reset", {31'h0, irq}, 32'h0);
`endif
    address = 2'd3;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'h0, irq}, 32'h0);
    check("async_readdata", readdata, 32'h0);
    in_port = 8'h00;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    check("post_reset_irq", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);
    check("post_reset_edgecap", rd, 32'h0);
    bus_read(2'd2, rd);
    check("post_reset_mask", rd, 32'h0);
    tick(4);
    bus_read(2'd3, rd);
    check("no_spurious_edge", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
